// File: rtl/frame_write_ctrl_pkg.sv
// frame_write_ctrl_pkg
// Shared definitions for the frame-buffer write controller and the display
// side that reads the same buffer: state encoding, default frame geometry,
// write-port widths and a counter-width helper.
// No ports (package).

package frame_write_ctrl_pkg;

  // Default stored frame geometry (display side reads the same constants)
  localparam int unsigned FWC_WIDTH_DEF  = 320;
  localparam int unsigned FWC_HEIGHT_DEF = 240;

  // Frame-buffer write port widths
  localparam int unsigned FWC_ADDR_W = 17;
  localparam int unsigned FWC_DATA_W = 24;

  // Controller state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    FWC_IDLE  = ST_IDLE,
    FWC_WRITE = ST_WRITE,
    FWC_DROP  = ST_DROP,
    FWC_DONE  = ST_DONE
  } fwc_state_e;

  // Bits needed to count 0..n-1, never less than one
  function automatic int unsigned fwc_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_write_addr_gen.sv
// frame_write_addr_gen
// Column / row / write-address counters for the frame write controller.
// A beat flagged sof_i is evaluated from the frame origin, so one control
// cycle both restarts the frame and advances past its first pixel.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   clr_i               return all counters to zero
//   sof_i               current beat starts a frame (count from origin)
//   inc_i               advance one column
//   line_i              advance to column 0 of the next row
//   store_i             current beat is stored (address advances)
//   col_o/row_o/addr_o  registered input position and next write address

module frame_write_addr_gen #(
  parameter int unsigned CW = 9,
  parameter int unsigned RW = 8,
  parameter int unsigned AW = 17
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          sof_i,
  input  logic          inc_i,
  input  logic          line_i,
  input  logic          store_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic [AW-1:0] addr_o
);

  logic [CW-1:0] col_q, col_d, base_col;
  logic [RW-1:0] row_q, row_d, base_row;
  logic [AW-1:0] addr_q, addr_d, base_addr;

  // Position the current beat is evaluated at
  assign base_col  = sof_i ? '0 : col_q;
  assign base_row  = sof_i ? '0 : row_q;
  assign base_addr = sof_i ? '0 : addr_q;

  // Counter next-state
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (clr_i) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (inc_i) begin
      col_d  = base_col + CW'(1);
      row_d  = base_row;
      addr_d = base_addr + AW'(store_i);
    end else if (line_i) begin
      col_d  = '0;
      row_d  = base_row + RW'(1);
      addr_d = base_addr + AW'(store_i);
    end
  end

  // Counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/frame_write_ctrl.sv
// frame_write_ctrl
// Accepts a raster pixel stream (SOF / EOL qualified beats) and writes it
// into a WIDTH x HEIGHT frame buffer, checking line geometry and reporting
// completion or corruption with single-cycle pulses.
// Optional feature: define FRAME_WRITE_DOWNSCALE_EN to accept a 2*WIDTH x
// 2*HEIGHT input and store only even columns of even lines.
// Ports:
//   piul1Clock, piul1Reset      clock, synchronous active-high reset
//   piul1Valid / poul1Ready     beat handshake
//   piul1StartOfFrame           beat is the first pixel of a frame
//   piul1EndOfLine              beat is the last pixel of a line
//   piul24Data                  RGB888 pixel, R in [23:16]
//   poul1WriteEnable, poul17WriteAddress, poul24WriteData
//                               registered frame-buffer write port
//   poul1FrameDone, poul1FrameError  single-cycle status pulses

module frame_write_ctrl
  import frame_write_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = FWC_WIDTH_DEF,
  parameter int unsigned HEIGHT = FWC_HEIGHT_DEF
) (
  input  logic        piul1Clock,
  input  logic        piul1Reset,
  input  logic        piul1Valid,
  output logic        poul1Ready,
  input  logic        piul1StartOfFrame,
  input  logic        piul1EndOfLine,
  input  logic [23:0] piul24Data,
  output logic        poul1WriteEnable,
  output logic [16:0] poul17WriteAddress,
  output logic [23:0] poul24WriteData,
  output logic        poul1FrameDone,
  output logic        poul1FrameError
);

`ifdef FRAME_WRITE_DOWNSCALE_EN
  localparam int unsigned SCALE = 2;
`else
  localparam int unsigned SCALE = 1;
`endif
  localparam int unsigned IN_W = WIDTH * SCALE;
  localparam int unsigned IN_H = HEIGHT * SCALE;
  localparam int unsigned CW   = fwc_bits(IN_W);
  localparam int unsigned RW   = fwc_bits(IN_H);
  localparam int unsigned AW   = FWC_ADDR_W;
  localparam int unsigned DW   = FWC_DATA_W;

  logic [1:0]    state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          ready_q, ready_d;

  logic [CW-1:0] col, eff_col;
  logic [RW-1:0] row, eff_row;
  logic [AW-1:0] addr, eff_addr;
  logic          ag_clr, ag_inc, ag_line;
  logic          accept, take, last_col, last_row, line_ok, store;

  frame_write_addr_gen #(
    .CW (CW),
    .RW (RW),
    .AW (AW)
  ) u_addr_gen (
    .clk_i   (piul1Clock),
    .rst_i   (piul1Reset),
    .clr_i   (ag_clr),
    .sof_i   (piul1StartOfFrame),
    .inc_i   (ag_inc),
    .line_i  (ag_line),
    .store_i (store),
    .col_o   (col),
    .row_o   (row),
    .addr_o  (addr)
  );

  // An SOF beat is always judged as the origin pixel, even mid-frame
  assign eff_col  = piul1StartOfFrame ? '0 : col;
  assign eff_row  = piul1StartOfFrame ? '0 : row;
  assign eff_addr = piul1StartOfFrame ? '0 : addr;

  assign accept   = piul1Valid && ready_q;
  // Only SOF beats matter outside WRITE; everything else is swallowed
  assign take     = accept && (piul1StartOfFrame || (state_q == ST_WRITE));
  assign last_col = (eff_col == CW'(IN_W - 1));
  assign last_row = (eff_row == RW'(IN_H - 1));
  assign line_ok  = (piul1EndOfLine == last_col);

`ifdef FRAME_WRITE_DOWNSCALE_EN
  assign store = ~eff_col[0] & ~eff_row[0];
`else
  assign store = 1'b1;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ag_clr  = 1'b0;
    ag_inc  = 1'b0;
    ag_line = 1'b0;
    case (state_q)
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        if (take) begin
          err_d = piul1StartOfFrame && (state_q == ST_WRITE);
          if (!line_ok) begin
            err_d   = 1'b1;
            state_d = ST_DROP;
          end else begin
            we_d = store;
            if (store) begin
              waddr_d = eff_addr;
              wdata_d = piul24Data;
            end
            if (piul1EndOfLine && last_row) begin
              state_d = ST_DONE;
              ag_clr  = 1'b1;
            end else begin
              state_d = ST_WRITE;
              ag_line = piul1EndOfLine;
              ag_inc  = ~piul1EndOfLine;
            end
          end
        end
      end
    endcase
    ready_d = (state_d != ST_DONE);
  end

  // State and output registers
  always_ff @(posedge piul1Clock) begin
    if (piul1Reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign poul1Ready         = ready_q;
  assign poul1WriteEnable   = we_q;
  assign poul17WriteAddress = waddr_q;
  assign poul24WriteData    = wdata_q;
  assign poul1FrameDone     = done_q;
  assign poul1FrameError    = err_q;

endmodule
